gram_uart_tx: RTL

Serial readback engine for the graphics card: on command, it reads a contiguous range of GRAM character cells through a second GRAM read port and transmits each 7-bit cell value as a UART 8N1 byte on `txd`. It is the transmit-side counterpart of the UART receiver that fills GRAM. A host can dump and verify the frame buffer over the same serial link. It runs on the 50 MHz system clock, alongside the receiver; it never writes GRAM.

---
 rtl/gram_uart_tx_if.sv | 19 +
 rtl/gram_uart_tx.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/gram_uart_tx_if.sv
// Command/status bundle between the host-side controller and the GRAM
// readback transmitter.
interface gram_uart_tx_if;
    logic        start;
    logic [11:0] start_address;
    logic [12:0] length;
    logic        busy;
    logic        done;

    modport master (
        output start, start_address, length,
        input  busy, done
    );

    modport slave (
        input  start, start_address, length,
        output busy, done
    );
endinterface

// File: rtl/gram_uart_tx.sv
// GRAM readback engine: reads a range of character cells and sends each
// 7-bit value as a UART 8N1 byte on txd.
module gram_uart_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int READ_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    gram_uart_tx_if.slave      cmd,
    output logic [11:0]        gram_read_address,
    input  logic [6:0]         gram_read_data,
    output logic               txd
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_START, S_DATA, S_STOP
    } state_e;

    state_e        state_q, state_d;
    logic [11:0]   addr_q, addr_d;
    logic [12:0]   remain_q, remain_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    lat_q, lat_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd.start) begin
                    if (cmd.length != 13'd0) begin
                        addr_d   = cmd.start_address;
                        remain_d = cmd.length;
                        busy_d   = 1'b1;
                        lat_d    = 2'd0;
                        state_d  = S_FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (lat_q == LAT_LAST) begin
                    shift_d = {1'b0, gram_read_data};
                    txd_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_START;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    txd_d     = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = 3'd0;
                    cnt_d     = '0;
                    state_d   = S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    remain_d = remain_q - 13'd1;
                    // remain_q==1 means this stop bit closes the last byte
                    if (remain_q == 13'd1) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = addr_q + 12'd1;
                        lat_d   = 2'd0;
                        state_d = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            cnt_q     <= '0;
            lat_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign gram_read_address = addr_q;
    assign txd               = txd_q;
    assign cmd.busy          = busy_q;
    assign cmd.done          = done_q;
endmodule
